// File: rtl/mesh_pkg.sv
// Shared mesh definitions: packet field layout, broadcast ID and packing/destination helpers
// used by the terminal injector, the router wrappers and the bench.
package mesh_pkg;

  localparam int JUMP_W    = 8;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 4;
  localparam int HDR_W     = JUMP_W + ROW_W + COL_W + 1;
  localparam int PAY_W_DEF = 15;

  localparam logic [7:0] BDCST_DEF = 8'hFF;

  typedef struct packed {
    logic [JUMP_W-1:0]    nxt_jump;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic                 mode;
    logic [PAY_W_DEF-1:0] payload;
  } mesh_pkt_t;

  // Header as injected by a terminal: the router fills nxt_jump, so it starts at zero.
  function automatic logic [HDR_W-1:0] pack_hdr(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col,
                                                input logic mode);
    return {{JUMP_W{1'b0}}, row, col, mode};
  endfunction

  function automatic mesh_pkt_t pack_pkt(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col,
                                         input logic mode,
                                         input logic [PAY_W_DEF-1:0] payload);
    mesh_pkt_t pkt;
    pkt.nxt_jump = {JUMP_W{1'b0}};
    pkt.row      = row;
    pkt.col      = col;
    pkt.mode     = mode;
    pkt.payload  = payload;
    return pkt;
  endfunction

  // Rows and columns are 1-based; the broadcast ID is always routable.
  function automatic logic dest_valid(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col,
                                      input logic [ROW_W-1:0] max_row,
                                      input logic [COL_W-1:0] max_col,
                                      input logic [7:0] bdcst);
    logic in_range;
    in_range = (row >= ROW_W'(1)) && (row <= max_row) &&
               (col >= COL_W'(1)) && (col <= max_col);
    return in_range || ({row, col} == bdcst);
  endfunction

endpackage

// File: rtl/terminal_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word, level and flags are all registered
// so the consumer sees clean outputs, and the head reads as zero while empty.
module terminal_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic [LW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push_i & ~full_r;
  assign pop_ok_s  = pop_i & ~empty_r;

  // Next occupancy and the word that will sit at the head after this edge.
  always_comb begin
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + LW'(1);
      2'b01:   count_nxt_s = count_r - LW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (pop_ok_s) begin
      if (count_r > LW'(1)) begin
        head_nxt_s = mem_r[rd_ptr_r + AW'(1)];
      end else if (push_ok_s) begin
        head_nxt_s = wdata_i;
      end else begin
        head_nxt_s = '0;
      end
    end else if (push_ok_s && (count_r == '0)) begin
      head_nxt_s = wdata_i;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

  // Pointers, occupancy, flags and registered head word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      head_r  <= head_nxt_s;
      empty_r <= (count_nxt_s == '0);
      full_r  <= (count_nxt_s == LW'(DEPTH));
    end
  end

  assign rdata_o = head_r;
  assign empty_o = empty_r;
  assign full_o  = full_r;
  assign level_o = count_r;

endmodule

// File: rtl/mesh_terminal_tx.sv
// Terminal-side mesh injector: packs client requests into mesh packets, drops unroutable ones,
// buffers the rest and presents them first-word-fall-through to the router input port.
module mesh_terminal_tx
  import mesh_pkg::*;
#(
  parameter int         ROWS       = 4,
  parameter int         COLUMNS    = 4,
  parameter int         PAKG_SIZE  = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] BDCST      = BDCST_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [3:0]                    req_row_i,
  input  logic [3:0]                    req_col_i,
  input  logic                          req_mode_i,
  input  logic [PAKG_SIZE-18:0]         req_payload_i,
  output logic                          pndng_i_in,
  output logic [PAKG_SIZE-1:0]          data_out_i_in,
  input  logic                          popin,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [15:0]                   sent_cnt_o,
  output logic                          err_o
);

  logic                 full_s;
  logic                 empty_s;
  logic                 accept_s;
  logic                 dest_ok_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 bad_pop_s;
  logic [PAKG_SIZE-1:0] pkt_s;
  logic [15:0]          sent_cnt_r;
  logic                 err_r;

  assign req_ready_o = ~full_s;
  assign pndng_i_in  = ~empty_s;

  assign accept_s  = req_valid_i & req_ready_o;
  assign dest_ok_s = dest_valid(req_row_i, req_col_i, ROW_W'(ROWS), COL_W'(COLUMNS), BDCST);
  assign push_s    = accept_s & dest_ok_s;
  assign pop_s     = popin & pndng_i_in;
  assign bad_pop_s = popin & ~pndng_i_in;
  assign pkt_s     = {pack_hdr(req_row_i, req_col_i, req_mode_i), req_payload_i};

  terminal_fifo #(
    .WIDTH (PAKG_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .wdata_i (pkt_s),
    .pop_i   (pop_s),
    .rdata_o (data_out_i_in),
    .empty_o (empty_s),
    .full_o  (full_s),
    .level_o (level_o)
  );

  // Delivered-packet counter and sticky protocol error flag; the error clears only on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sent_cnt_r <= 16'd0;
      err_r      <= 1'b0;
    end else begin
      if (pop_s) sent_cnt_r <= sent_cnt_r + 16'd1;
      if (bad_pop_s || (accept_s && !dest_ok_s)) err_r <= 1'b1;
    end
  end

  assign sent_cnt_o = sent_cnt_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_mesh_terminal_tx.sv
// Self-checking bench for mesh_terminal_tx: directed scenarios plus random traffic, with an
// occupancy model and an expected-packet queue drained by an independent pop monitor.
module tb_mesh_terminal_tx;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_row_i;
  logic [3:0]  req_col_i;
  logic        req_mode_i;
  logic [14:0] req_payload_i;
  logic        pndng_i_in;
  logic [31:0] data_out_i_in;
  logic        popin;
  logic [4:0]  level_o;
  logic [15:0] sent_cnt_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  int          m_level = 0;
  int          m_sent  = 0;
  bit          m_err   = 1'b0;
  logic [31:0] exp_q[$];

  mesh_terminal_tx dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_row_i     (req_row_i),
    .req_col_i     (req_col_i),
    .req_mode_i    (req_mode_i),
    .req_payload_i (req_payload_i),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .level_o       (level_o),
    .sent_cnt_o    (sent_cnt_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pkt(input int r, input int c, input int m, input int p);
    return 32'((r << 20) | (c << 16) | (m << 15) | p);
  endfunction

  function automatic bit model_dest_ok(input int r, input int c);
    return (r >= 1 && r <= 4 && c >= 1 && c <= 4) || (r == 15 && c == 15);
  endfunction

  task automatic check_outputs();
    chk("ready", 32'(req_ready_o), 32'(m_level < DEPTH));
    chk("pndng", 32'(pndng_i_in), 32'(m_level > 0));
    chk("level", 32'(level_o), 32'(m_level));
    chk("sent_cnt", 32'(sent_cnt_o), 32'(m_sent & 32'hFFFF));
    chk("err", 32'(err_o), 32'(m_err));
    if (m_level == 0) chk("data_empty", data_out_i_in, 32'h0);
  endtask

  // One clock of traffic: drive, let the edge happen, advance the model, compare.
  task automatic do_cycle(input bit v, input int r, input int c, input int m, input int p,
                          input bit pi, output bit accepted);
    bit acc;
    req_valid_i   = v;
    req_row_i     = 4'(r);
    req_col_i     = 4'(c);
    req_mode_i    = 1'(m);
    req_payload_i = 15'(p);
    popin         = pi;
    @(posedge clk_i);
    #1;
    acc = v && (m_level < DEPTH);
    if (pi && m_level == 0) m_err = 1'b1;
    if (acc && !model_dest_ok(r, c)) m_err = 1'b1;
    if (pi && m_level > 0) begin
      m_level--;
      m_sent++;
    end
    if (acc && model_dest_ok(r, c)) begin
      m_level++;
      exp_q.push_back(model_pkt(r, c, m, p));
    end
    accepted = acc;
    check_outputs();
  endtask

  task automatic reset_dut();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_pndng", 32'(pndng_i_in), 32'h0);
    chk("rst_level", 32'(level_o), 32'h0);
    chk("rst_sent", 32'(sent_cnt_o), 32'h0);
    chk("rst_data", data_out_i_in, 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h1);
    chk("rst_err", 32'(err_o), 32'h0);
    m_level = 0;
    m_sent  = 0;
    m_err   = 1'b0;
    exp_q.delete();
    req_valid_i = 1'b0;
    popin       = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Pop monitor: whenever the router side pops a presented packet, it must be the oldest expected one.
  always @(negedge clk_i) begin
    if (!rst_i && pndng_i_in && popin) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", data_out_i_in, 32'hxxxx_xxxx);
      end else begin
        chk("pop_data", data_out_i_in, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit pend;
    int rr, cc, mm, pp;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_row_i = 4'd0; req_col_i = 4'd0;
    req_mode_i = 1'b0; req_payload_i = 15'd0; popin = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs();
    rst_i = 1'b0;

    // Single push shows up one cycle later with the documented packing.
    do_cycle(1'b1, 2, 3, 0, 5, 1'b0, acc);
    chk("t1_data", data_out_i_in, 32'h0023_0005);
    do_cycle(1'b0, 0, 0, 0, 0, 1'b1, acc);

    // Fill to full, hold a 17th request, free one slot, then it goes in.
    reset_dut();
    for (int i = 0; i < 16; i++)
      do_cycle(1'b1, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 1),
               $urandom_range(0, 32767), 1'b0, acc);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 4, 4, 1, 16'h1234, 1'b0, acc);
    do_cycle(1'b1, 4, 4, 1, 16'h1234, 1'b1, acc);
    do_cycle(1'b1, 4, 4, 1, 16'h1234, 1'b0, acc);

    // Drain with back-to-back pops.
    for (int i = 0; i < 40 && m_level > 0; i++) do_cycle(1'b0, 0, 0, 0, 0, 1'b1, acc);

    // Push and pop together on an empty buffer.
    do_cycle(1'b1, 1, 1, 1, 7, 1'b1, acc);
    do_cycle(1'b0, 0, 0, 0, 0, 1'b1, acc);

    // Unroutable destination is consumed but dropped; broadcast is queued.
    reset_dut();
    do_cycle(1'b1, 5, 1, 0, 3, 1'b0, acc);
    do_cycle(1'b0, 0, 0, 0, 0, 1'b0, acc);
    reset_dut();
    do_cycle(1'b1, 15, 15, 0, 9, 1'b0, acc);
    chk("bcast_data", data_out_i_in, 32'h00FF_0009);
    do_cycle(1'b0, 0, 0, 0, 0, 1'b1, acc);

    // Reset with seven packets in flight.
    for (int i = 0; i < 7; i++)
      do_cycle(1'b1, $urandom_range(1, 4), $urandom_range(1, 4), 0, i, 1'b0, acc);
    reset_dut();

    // Random traffic with request hold until accepted.
    pend = 1'b0;
    rr = 0; cc = 0; mm = 0; pp = 0;
    for (int i = 0; i < 500; i++) begin
      if (!pend && $urandom_range(0, 99) < 60) begin
        int k;
        pend = 1'b1;
        k = $urandom_range(0, 39);
        if (k == 0) begin
          rr = 15; cc = 15;
        end else if (k == 1) begin
          rr = $urandom_range(0, 15); cc = $urandom_range(0, 15);
        end else begin
          rr = $urandom_range(1, 4); cc = $urandom_range(1, 4);
        end
        mm = $urandom_range(0, 1);
        pp = $urandom_range(0, 32767);
      end
      do_cycle(pend, rr, cc, mm, pp, $urandom_range(0, 99) < 45, acc);
      if (acc) pend = 1'b0;
    end
    for (int i = 0; i < 40 && m_level > 0; i++) do_cycle(1'b0, 0, 0, 0, 0, 1'b1, acc);
    chk("drain_queue", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
